// File: rtl/lsu_core.sv
`default_nettype none
// ============================================================================
// lsu_core : load/store unit with lane alignment, 1-entry pending slot and
//            load-response timeout.
// Revision : 1.0
// ============================================================================
module lsu_core #(
  parameter int TMO_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  input  logic        lsu_sx,
  input  logic        err_clr,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic        lsu_busy,
  output logic        lsu_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_a,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wd,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        sx;
  } entry_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t     r_state, w_state_nxt;
  entry_t     r_cur, w_cur_nxt, r_pnd, w_pnd_nxt, w_new;
  logic       r_pnd_vld, w_pnd_vld_nxt;
  logic [7:0] r_tmo, w_tmo_nxt;

  logic        w_is_st, w_is_ld, w_mask_ok, w_legal, w_illegal;
  logic [3:0]  w_mask;
  logic [1:0]  w_sz;
  logic        w_done, w_ld_done, w_tmo_hit, w_drop, w_err_set;
  logic [31:0] w_shift, w_ld_data;

  // Request decode; the bus-side view of the access is built here so it is
  // frozen at the request cycle.
  always_comb begin
    w_is_st   = |lsu_we;
    w_is_ld   = |lsu_re;
    w_mask    = w_is_st ? lsu_we : lsu_re;
    w_sz      = 2'd0;
    w_mask_ok = 1'b0;
    case (w_mask)
      4'b0001: begin w_sz = 2'd0; w_mask_ok = 1'b1;                   end
      4'b0011: begin w_sz = 2'd1; w_mask_ok = ~lsu_a[0];              end
      4'b1111: begin w_sz = 2'd2; w_mask_ok = (lsu_a[1:0] == 2'b00);  end
      default: ;
    endcase
    w_legal   = (w_is_st ^ w_is_ld) & w_mask_ok;
    w_illegal = (w_is_st | w_is_ld) & ~w_legal;
    w_new.we  = w_is_st;
    w_new.a   = {lsu_a[31:2], 2'b00};
    w_new.be  = w_mask << lsu_a[1:0];
    w_new.wd  = lsu_wd << {lsu_a[1:0], 3'b000};
    w_new.off = lsu_a[1:0];
    w_new.sz  = w_sz;
    w_new.sx  = lsu_sx;
  end

  always_comb begin
    w_shift = dm_rd >> {r_cur.off, 3'b000};
    case (r_cur.sz)
      2'd0:    w_ld_data = {{24{r_cur.sx & w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ld_data = {{16{r_cur.sx & w_shift[15]}}, w_shift[15:0]};
      default: w_ld_data = w_shift;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_pnd_nxt     = r_pnd;
    w_pnd_vld_nxt = r_pnd_vld;
    w_tmo_nxt     = r_tmo;
    w_done        = 1'b0;
    w_ld_done     = 1'b0;
    w_tmo_hit     = 1'b0;
    w_drop        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_legal) begin
          w_cur_nxt   = w_new;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (dm_gnt) begin
          if (r_cur.we) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = RESP;
            w_tmo_nxt   = 8'd0;
          end
        end
      end
      RESP: begin
        if (dm_rvalid) begin
          w_done    = 1'b1;
          w_ld_done = 1'b1;
        end else if (r_tmo == TMO_LAST) begin
          w_done    = 1'b1;
          w_tmo_hit = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Completion hands over straight to the oldest waiting access, so the
    // bus never sees an idle bubble between queued requests.
    if (r_state != IDLE) begin
      if (w_done) begin
        w_state_nxt = IDLE;
        if (r_pnd_vld) begin
          w_cur_nxt     = r_pnd;
          w_state_nxt   = REQ;
          w_pnd_vld_nxt = w_legal;
          if (w_legal) w_pnd_nxt = w_new;
        end else if (w_legal) begin
          w_cur_nxt   = w_new;
          w_state_nxt = REQ;
        end
      end else if (w_legal) begin
        if (r_pnd_vld) begin
          w_drop = 1'b1;
        end else begin
          w_pnd_nxt     = w_new;
          w_pnd_vld_nxt = 1'b1;
        end
      end
    end

    w_err_set = w_illegal | w_drop | w_tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cur     <= '0;
      r_pnd     <= '0;
      r_pnd_vld <= 1'b0;
      r_tmo     <= 8'd0;
      lsu_vld   <= 1'b0;
      lsu_rd    <= 32'd0;
      lsu_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_pnd     <= w_pnd_nxt;
      r_pnd_vld <= w_pnd_vld_nxt;
      r_tmo     <= w_tmo_nxt;
      lsu_vld   <= w_ld_done;
      if (w_ld_done) lsu_rd <= w_ld_data;
      if (w_err_set)    lsu_err <= 1'b1;
      else if (err_clr) lsu_err <= 1'b0;
    end
  end

  assign dm_req   = (r_state == REQ);
  assign dm_we    = dm_req & r_cur.we;
  assign dm_a     = r_cur.a;
  assign dm_be    = r_cur.be;
  assign dm_wd    = r_cur.wd;
  assign lsu_busy = (r_state != IDLE) | r_pnd_vld;

endmodule
`default_nettype wire

// File: tb/tb_lsu_core.sv
`timescale 1ns/1ps
`default_nettype none
// tb_lsu_core : directed scenarios with a load-result scoreboard.
module tb_lsu_core;
  localparam int TMO = 16;

  logic        clk = 1'b0, rstn = 1'b0;
  logic [31:0] lsu_a = '0, lsu_wd = '0, dm_rd = '0;
  logic [3:0]  lsu_we = '0, lsu_re = '0;
  logic        lsu_sx = 1'b0, err_clr = 1'b0, dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic        lsu_vld, lsu_busy, lsu_err, dm_req, dm_we;
  logic [31:0] lsu_rd, dm_a, dm_wd;
  logic [3:0]  dm_be;

  int          n_pass = 0, n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  lsu_core #(.TMO_CYC(TMO)) u_lsu (
    .clk(clk), .rstn(rstn), .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd),
    .lsu_re(lsu_re), .lsu_sx(lsu_sx), .err_clr(err_clr), .lsu_vld(lsu_vld),
    .lsu_rd(lsu_rd), .lsu_busy(lsu_busy), .lsu_err(lsu_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_a(dm_a), .dm_be(dm_be), .dm_wd(dm_wd), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rd(dm_rd)
  );

  // Scoreboard: every lsu_vld must match the oldest expected load result.
  always @(negedge clk) begin
    if (lsu_vld === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_vld: got lsu_rd=%h, required no lsu_vld", lsu_rd);
      end else begin
        mon_exp = exp_q.pop_front();
        if (lsu_rd !== mon_exp)
          $display("FAIL sb_load_data: got %h, required %h", lsu_rd, mon_exp);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_load(input logic [31:0] a, input logic [3:0] m, input logic sx,
                          input logic [31:0] rd, input logic [31:0] exp);
    exp_q.push_back(exp);
    lsu_a = a; lsu_re = m; lsu_sx = sx; tick();
    lsu_re = '0; dm_gnt = 1'b1; tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rd = rd; tick();
    dm_rvalid = 1'b0; tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; tick(); tick();
    @(negedge clk);
    n_total++;
    if ({dm_req, dm_we, dm_be, dm_a, dm_wd} !== 70'd0)
      $display("FAIL reset_bus: got %h, required 0", {dm_req, dm_we, dm_be, dm_a, dm_wd});
    else n_pass++;
    n_total++;
    if ({lsu_vld, lsu_rd, lsu_busy, lsu_err} !== 35'd0)
      $display("FAIL reset_lsu: got %h, required 0", {lsu_vld, lsu_rd, lsu_busy, lsu_err});
    else n_pass++;
    tick(); rstn = 1'b1; tick();
  endtask

  task automatic test_word_load();
    lsu_a = 32'h100; lsu_re = 4'hF; lsu_sx = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_total++;
    if (dm_req !== 1'b0) $display("FAIL wl_req_cycle_n: got dm_req=%b, required 0", dm_req);
    else n_pass++;
    tick(); lsu_re = '0; lsu_a = 32'hFFFF_FFFF; dm_gnt = 1'b1;
    @(negedge clk);
    n_total++;
    if ({dm_req, dm_we, dm_a, dm_be} !== {1'b1, 1'b0, 32'h100, 4'hF})
      $display("FAIL wl_req_n1: got %h, required %h", {dm_req, dm_we, dm_a, dm_be},
               {1'b1, 1'b0, 32'h100, 4'hF});
    else n_pass++;
    tick(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rd = 32'hDEADBEEF;
    @(negedge clk);
    n_total++;
    if ({dm_req, lsu_vld} !== 2'b00) $display("FAIL wl_resp_n2: got %b, required 00", {dm_req, lsu_vld});
    else n_pass++;
    tick(); dm_rvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({lsu_vld, lsu_rd} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL wl_vld_n3: got %h, required %h", {lsu_vld, lsu_rd}, {1'b1, 32'hDEADBEEF});
    else n_pass++;
    tick();
  endtask

  task automatic test_load_extract();
    bus_load(32'h103, 4'b0001, 1'b1, 32'h80123456, 32'hFFFFFF80);
    bus_load(32'h103, 4'b0001, 1'b0, 32'h80123456, 32'h00000080);
    bus_load(32'h102, 4'b0011, 1'b1, 32'h80123456, 32'hFFFF8012);
    bus_load(32'h100, 4'b0011, 1'b0, 32'h1234F00D, 32'h0000F00D);
    bus_load(32'h101, 4'b0001, 1'b1, 32'h1234F07D, 32'hFFFFFFF0);
  endtask

  task automatic test_half_store();
    lsu_a = 32'h202; lsu_we = 4'b0011; lsu_wd = 32'h0000ABCD; tick();
    lsu_we = '0; lsu_wd = 32'hFFFF_FFFF; lsu_a = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dm_gnt = 1'b1;
      @(negedge clk);
      n_total++;
      if ({dm_req, dm_we, dm_a, dm_be, dm_wd} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD0000})
        $display("FAIL hs_hold_%0d: got %h, required %h", i, {dm_req, dm_we, dm_a, dm_be, dm_wd},
                 {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD0000});
      else n_pass++;
      tick();
    end
    dm_gnt = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dm_req, lsu_busy, lsu_vld} !== 3'b000)
      $display("FAIL hs_done: got %b, required 000", {dm_req, lsu_busy, lsu_vld});
    else n_pass++;
    tick();
  endtask

  task automatic test_illegal();
    lsu_a = 32'h101; lsu_re = 4'hF; tick(); lsu_re = '0;
    @(negedge clk);
    n_total++;
    if ({dm_req, lsu_busy, lsu_err} !== 3'b001)
      $display("FAIL il_misaligned: got %b, required 001", {dm_req, lsu_busy, lsu_err});
    else n_pass++;
    tick(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    @(negedge clk);
    n_total++;
    if (lsu_err !== 1'b0) $display("FAIL il_err_clr: got %b, required 0", lsu_err);
    else n_pass++;
    // Illegal mask with err_clr in the same cycle: the set must win.
    tick(); lsu_a = 32'h100; lsu_re = 4'b0101; err_clr = 1'b1; tick();
    lsu_re = '0; err_clr = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dm_req, lsu_err} !== 2'b01) $display("FAIL il_mask_prio: got %b, required 01", {dm_req, lsu_err});
    else n_pass++;
    tick(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    lsu_we = 4'b0001; lsu_re = 4'b0001; tick(); lsu_we = '0; lsu_re = '0;
    @(negedge clk);
    n_total++;
    if ({dm_req, lsu_busy, lsu_err} !== 3'b001)
      $display("FAIL il_both: got %b, required 001", {dm_req, lsu_busy, lsu_err});
    else n_pass++;
    tick(); err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int seen_req;
    lsu_a = 32'h300; lsu_re = 4'hF; exp_q.push_back(32'hCAFEF00D); tick();
    lsu_re = '0; lsu_a = 32'h304; lsu_we = 4'hF; lsu_wd = 32'h11223344;
    @(negedge clk);
    n_total++;
    if ({dm_req, dm_a} !== {1'b1, 32'h300}) $display("FAIL bb_first_req: got %h, required %h",
                                                     {dm_req, dm_a}, {1'b1, 32'h300});
    else n_pass++;
    tick(); lsu_we = '0; lsu_a = 32'h308; lsu_re = 4'hF;
    tick(); lsu_re = '0; dm_gnt = 1'b1;
    @(negedge clk);
    n_total++;
    if ({lsu_err, lsu_busy, dm_req, dm_a} !== {3'b111, 32'h300})
      $display("FAIL bb_drop: got %h, required %h", {lsu_err, lsu_busy, dm_req, dm_a}, {3'b111, 32'h300});
    else n_pass++;
    tick(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rd = 32'hCAFEF00D;
    tick(); dm_rvalid = 1'b0; dm_gnt = 1'b1;
    @(negedge clk);
    n_total++;
    if ({dm_req, dm_we, dm_a, dm_be, dm_wd} !== {2'b11, 32'h304, 4'hF, 32'h11223344})
      $display("FAIL bb_second_issue: got %h, required %h", {dm_req, dm_we, dm_a, dm_be, dm_wd},
               {2'b11, 32'h304, 4'hF, 32'h11223344});
    else n_pass++;
    tick(); dm_gnt = 1'b0;
    seen_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dm_req !== 1'b0 || lsu_busy !== 1'b0) seen_req++;
      tick();
    end
    n_total++;
    if (seen_req !== 0) $display("FAIL bb_third_issued: got %0d busy cycles, required 0", seen_req);
    else n_pass++;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt, early;
    cnt = 0; early = 0;
    lsu_a = 32'h400; lsu_re = 4'hF; tick();
    lsu_re = '0; dm_gnt = 1'b1; tick(); dm_gnt = 1'b0;
    while (cnt < 40) begin
      @(negedge clk);
      if (lsu_busy !== 1'b1) break;
      if (lsu_err !== 1'b0 || dm_req !== 1'b0) early++;
      cnt++;
      tick();
    end
    n_total++;
    if (cnt !== TMO) $display("FAIL tmo_cycles: got %0d RESP cycles, required %0d", cnt, TMO);
    else n_pass++;
    n_total++;
    if (early !== 0) $display("FAIL tmo_early: got %0d bad RESP cycles, required 0", early);
    else n_pass++;
    n_total++;
    if ({lsu_err, lsu_vld} !== 2'b10) $display("FAIL tmo_err: got %b, required 10", {lsu_err, lsu_vld});
    else n_pass++;
    // A late rvalid in IDLE must be ignored.
    tick(); dm_rvalid = 1'b1; dm_rd = 32'h12345678; tick(); dm_rvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({lsu_vld, lsu_busy} !== 2'b00) $display("FAIL tmo_late_rvalid: got %b, required 00", {lsu_vld, lsu_busy});
    else n_pass++;
    tick(); err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    lsu_a = 32'h500; lsu_re = 4'hF; tick();
    lsu_re = '0; dm_gnt = 1'b1; tick(); dm_gnt = 1'b0;
    rstn = 1'b0; tick(); rstn = 1'b1;
    dm_rvalid = 1'b1; dm_rd = 32'hA5A5A5A5;
    @(negedge clk);
    n_total++;
    if ({lsu_busy, dm_req, lsu_err, lsu_vld} !== 4'b0000)
      $display("FAIL rm_state: got %b, required 0000", {lsu_busy, dm_req, lsu_err, lsu_vld});
    else n_pass++;
    tick(); dm_rvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (lsu_vld !== 1'b0) $display("FAIL rm_no_vld: got %b, required 0", lsu_vld);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_load_extract();
    test_half_store();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    tick(); tick();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL sb_missing_vld: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
